mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter and sequencer sharing the single memory bus between the instruction-fetch requester and the load/store (data) requester. It accepts one request at a time and drives the memory request/response handshake. It returns read data or write acknowledgement to the winning port. It sits between the fetch/load-store units and the memory model, replacing their direct connection to the bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 16, max WAIT cycles before abort (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- if_req_valid  in  1  fetch request, held until if_data_valid
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req_valid
- if_grant  out  1  one-cycle pulse: fetch request accepted
- if_rdata  out  DATA_WIDTH  fetched word, registered, held until next fetch response
- if_data_valid  out  1  one-cycle pulse: if_rdata valid
- d_req_valid  in  1  data request, held until d_data_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_grant  out  1  one-cycle pulse: data request accepted
- d_rdata  out  DATA_WIDTH  load data, registered, held until next data response
- d_data_valid  out  1  one-cycle pulse: load data valid or store done
- mem_req_valid  out  1  memory request, held from ISSUE through WAIT
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address (latched at grant)
- mem_wdata  out  DATA_WIDTH  memory write data (latched at grant)
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_data_valid
- mem_data_valid  in  1  memory response / write ack
- owner  out  1  0 = fetch, 1 = data; meaningful when busy=1
- busy  out  1  1 in any state except IDLE
- timeout_err  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample if_req_valid and d_req_valid.
  - If either is set, pick a winner per arbitration policy and pulse its grant.
  - Latch addr, we and wdata into the mem_* registers; data wdata is latched, and for fetch mem_we=0 and mem_wdata=0.
  - Set owner and go to ISSUE.
- ISSUE: mem_req_valid=1; clear the timeout counter; go to WAIT.
- WAIT: mem_req_valid stays 1 and the counter increments each cycle.
  - On mem_data_valid: capture mem_rdata into the owner's rdata register (writes capture nothing and the rdata register keeps its old value), then go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without mem_data_valid: load 0 into the owner's rdata, pulse timeout_err, go to RESP.
- RESP: mem_req_valid=0; pulse the owner's data_valid; update last_owner; go to IDLE.
- mem_data_valid is ignored in IDLE, ISSUE and RESP.
- Reset, asynchronous, at any time including mid-transaction:
  - state goes to IDLE and the in-flight transaction is dropped;
  - all outputs and rdata registers go to 0, and last_owner goes to 1;
  - a late mem_data_valid after reset is ignored.

## Timing
- Request seen in IDLE at cycle N:
  - grant pulses at N;
  - ISSUE at N+1, with mem_req_valid first high at N+1;
  - WAIT from N+2.
- mem_data_valid at cycle M (in WAIT): RESP at M+1 with data_valid high for M+1 only; IDLE at M+2.
- Minimum request-to-data_valid latency: 3 cycles plus the memory latency. Minimum gap between consecutive grants: 4 cycles.
- Requesters drop req_valid on the edge following their data_valid. A req_valid still high at M+2 is a new request.
- A requester that is not granted keeps req_valid asserted, and it is re-arbitrated at the next IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both ports request in the same IDLE cycle, the port that is not last_owner wins. last_owner resets to 1, so the first contested grant goes to fetch.
- Not defined: fixed priority, data always wins contention, and last_owner is unused.
- In both modes, a single requester always wins immediately.

## Test plan
- Reset, then fetch-only read of if_addr=0x10 with memory returning 0xDEADBEEF after 2 WAIT cycles:
  - if_grant pulses at N;
  - mem_req_valid is high from N+1 to N+3;
  - if_data_valid at N+4 with if_rdata=0xDEADBEEF.
- Data write: d_addr=0x20, d_wdata=0x12345678 → mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; d_data_valid pulses; d_rdata unchanged.
- Contention, both requesting every IDLE for 4 transactions:
  - with ARB_ROUND_ROBIN_EN, grant order is if, d, if, d;
  - without it, order is d, d, d, d and fetch starves.
- Timeout: memory never responds, TIMEOUT_CYCLES=16 → after 16 WAIT cycles, timeout_err and d_data_valid pulse together with d_rdata=0, then IDLE.
- Reset mid-WAIT, then mem_data_valid 2 cycles after reset release → all outputs 0, no data_valid pulse, busy=0.
- Back-to-back fetches with requester dropping req_valid after data_valid → exactly one grant per request and no duplicate transaction.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter/sequencer: fetch vs load/store, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise data has fixed priority.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_grant,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_data_valid,
    input  logic                  d_req_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_grant,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_data_valid,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  owner,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  owner_q, busy_q, mem_req_valid_q, mem_we_q;
    logic                  if_dv_q, d_dv_q, tmo_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic                  pick_d, idle_w, take_if, take_d, tmo_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q;
    // On contention the port that did not own the previous transaction wins.
    assign pick_d = d_req_valid && (!if_req_valid || !last_owner_q);
`else
    assign pick_d = d_req_valid;
`endif

    // Grant is combinational so it pulses in the IDLE cycle that samples the request.
    assign idle_w  = (state_q == S_IDLE) && !reset;
    assign take_d  = idle_w && pick_d;
    assign take_if = idle_w && if_req_valid && !pick_d;
    assign cnt_d   = cnt_q + 1'b1;
    assign tmo_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            owner_q         <= 1'b0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            if_rdata_q      <= '0;
            d_rdata_q       <= '0;
            if_dv_q         <= 1'b0;
            d_dv_q          <= 1'b0;
            tmo_q           <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q    <= 1'b1;
`endif
        end else begin
            if_dv_q <= 1'b0;
            d_dv_q  <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take_d || take_if) begin
                        owner_q         <= take_d;
                        busy_q          <= 1'b1;
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= take_d && d_we;
                        mem_addr_q      <= take_d ? d_addr : if_addr;
                        mem_wdata_q     <= take_d ? d_wdata : '0;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_data_valid) begin
                        // Writes leave the requester's read data untouched.
                        if (!mem_we_q) begin
                            if (owner_q) d_rdata_q  <= mem_rdata;
                            else         if_rdata_q <= mem_rdata;
                        end
                        mem_req_valid_q <= 1'b0;
                        if_dv_q         <= !owner_q;
                        d_dv_q          <= owner_q;
                        state_q         <= S_RESP;
                    end else if (tmo_hit) begin
                        if (owner_q) d_rdata_q  <= '0;
                        else         if_rdata_q <= '0;
                        mem_req_valid_q <= 1'b0;
                        if_dv_q         <= !owner_q;
                        d_dv_q          <= owner_q;
                        tmo_q           <= 1'b1;
                        state_q         <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_q <= owner_q;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_grant      = take_if;
    assign d_grant       = take_d;
    assign if_rdata      = if_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign if_data_valid = if_dv_q;
    assign d_data_valid  = d_dv_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign owner         = owner_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed plan items plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int TMO = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_grant;
    logic [31:0] if_rdata;
    logic        if_data_valid;
    logic        d_req_valid = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_grant;
    logic [31:0] d_rdata;
    logic        d_data_valid;
    logic        mem_req_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;
    logic        owner;
    logic        busy;
    logic        timeout_err;

    int          n_chk = 0;
    int          n_fail = 0;

    // Reference model state: what each requester should currently hold.
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    bit          last_own     = 1'b1;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_grant(if_grant),
        .if_rdata(if_rdata), .if_data_valid(if_data_valid),
        .d_req_valid(d_req_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_rdata(d_rdata), .d_data_valid(d_data_valid),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from an IDLE cycle (called at posedge+1 with requests driven).
    // lat = WAIT cycle on which memory answers; 0 = memory never answers.
    task automatic txn(input int lat, input logic [31:0] rv, output bit won_d);
        bit          gd, gi, tmo, ewe;
        int          waits, last;
        logic [31:0] ea, ew;
        if (d_req_valid && if_req_valid) gd = RR ? (last_own == 1'b0) : 1'b1;
        else                             gd = d_req_valid;
        gi    = if_req_valid && !gd;
        won_d = gd;
        tmo   = (lat == 0);
        waits = tmo ? TMO : lat;
        last  = 2 + waits;
        ea    = gd ? d_addr : if_addr;
        ewe   = gd && d_we;
        ew    = gd ? d_wdata : 32'h0;
        @(negedge clk);
        chk("if_grant", {31'b0, if_grant}, {31'b0, gi});
        chk("d_grant", {31'b0, d_grant}, {31'b0, gd});
        chk("busy_idle", {31'b0, busy}, 32'h0);
        chk("mreq_idle", {31'b0, mem_req_valid}, 32'h0);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            mem_rdata      = $urandom;
            mem_data_valid = 1'b0;
            if (c == 1 || c == last) mem_data_valid = 1'($urandom_range(0, 1));
            if (!tmo && c == 1 + lat) begin
                mem_data_valid = 1'b1;
                mem_rdata      = rv;
            end
            @(negedge clk);
            chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, (c <= 1 + waits)});
            chk("busy", {31'b0, busy}, 32'h1);
            chk("grant_busy", {30'b0, if_grant, d_grant}, 32'h0);
            chk("if_data_valid", {31'b0, if_data_valid}, {31'b0, (gi && c == last)});
            chk("d_data_valid", {31'b0, d_data_valid}, {31'b0, (gd && c == last)});
            chk("timeout_err", {31'b0, timeout_err}, {31'b0, (tmo && c == last)});
            chk("owner", {31'b0, owner}, {31'b0, gd});
            if (c == 1) begin
                chk("mem_addr", mem_addr, ea);
                chk("mem_we", {31'b0, mem_we}, {31'b0, ewe});
                chk("mem_wdata", mem_wdata, ew);
            end
            if (c == last) begin
                if (tmo) begin
                    if (gd) exp_d_rdata = 32'h0; else exp_if_rdata = 32'h0;
                end else if (!ewe) begin
                    if (gd) exp_d_rdata = rv; else exp_if_rdata = rv;
                end
                last_own = gd;
                chk("if_rdata", if_rdata, exp_if_rdata);
                chk("d_rdata", d_rdata, exp_d_rdata);
            end
        end
        @(posedge clk); #1;
        if (gd) d_req_valid = 1'b0; else if_req_valid = 1'b0;
        mem_data_valid = 1'b0;
    endtask

    initial begin
        bit wd;
        int lat;

        // Reset state
        #12;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mreq", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_dv", {30'b0, if_data_valid, d_data_valid}, 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Fetch-only read, memory answers on the 2nd WAIT cycle
        if_req_valid = 1'b1; if_addr = 32'h10;
        txn(2, 32'hDEADBEEF, wd);

        // Dropped request must not produce a second grant
        @(negedge clk);
        chk("no_dup_grant", {30'b0, if_grant, d_grant}, 32'h0);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Data write leaves d_rdata alone
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        txn(1, 32'hA5A5A5A5, wd);

        // Data read
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        txn(3, 32'hCAFEF00D, wd);

        // Contention: both ports request at every IDLE
        if_req_valid = 1'b1; if_addr = 32'h100;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            txn(1, $urandom, wd);
            if (wd) d_req_valid = 1'b1; else if_req_valid = 1'b1;
        end
        txn(1, $urandom, wd);
        if (if_req_valid || d_req_valid) txn(1, $urandom, wd);

        // Timeout on a data read
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        txn(0, 32'h0, wd);

        // Back-to-back fetches
        for (int k = 0; k < 3; k++) begin
            if_req_valid = 1'b1; if_addr = 32'h400 + 32'(k * 4);
            txn(1 + k, $urandom, wd);
        end

        // Randomized traffic; a losing requester keeps its request pending
        for (int k = 0; k < 25; k++) begin
            if (!if_req_valid && $urandom_range(0, 2) != 0) begin
                if_req_valid = 1'b1; if_addr = $urandom;
            end
            if (!d_req_valid && $urandom_range(0, 2) != 0) begin
                d_req_valid = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (!if_req_valid && !d_req_valid) begin
                if_req_valid = 1'b1; if_addr = $urandom;
            end
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            txn(lat, $urandom, wd);
        end
        if (if_req_valid || d_req_valid) txn(1, $urandom, wd);
        if (if_req_valid || d_req_valid) txn(1, $urandom, wd);

        // Make d_rdata nonzero, then reset in the middle of a fetch WAIT
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        txn(1, 32'h13572468, wd);
        if_req_valid = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk("pre_rst_grant", {31'b0, if_grant}, 32'h1);
        repeat (3) @(posedge clk);
        #3; reset = 1'b1; if_req_valid = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_mreq", {31'b0, mem_req_valid}, 32'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_d_rdata", d_rdata, 32'h0);
        chk("mid_rst_owner", {31'b0, owner}, 32'h0);
        exp_if_rdata = '0; exp_d_rdata = '0; last_own = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_data_valid = 1'b1; mem_rdata = 32'hBADBAD00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("late_dv", {30'b0, if_data_valid, d_data_valid}, 32'h0);
            chk("late_busy", {31'b0, busy}, 32'h0);
            chk("late_mreq", {31'b0, mem_req_valid}, 32'h0);
            chk("late_if_rdata", if_rdata, 32'h0);
            @(posedge clk); #1;
            mem_data_valid = 1'b0;
        end

        // Operation resumes after reset, contention policy restarted
        if_req_valid = 1'b1; if_addr = 32'h600;
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h604; d_wdata = 32'h0F0F0F0F;
        txn(2, 32'h77665544, wd);
        txn(1, 32'h11223344, wd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
